sub_vec_scheduler: RTL and testbench
====================================

// Module: sub_vec_scheduler
// PURPOSE
// Sequences the 32-lane element-wise subtractor datapath over vectors longer than one beat.
// A job is (L base, E base, D base, length in beats). The block issues one paired L/E read
// per cycle to the operand RAMs, whose data feed the subtractor directly, and tracks in-flight
// beats through the fixed, non-stallable pipeline. It writes each difference beat to the
// result RAM at the matching address.
// PARAMETERS
// W        6    bits per element (informational; widths of data paths outside this block)
// WC       32   elements per beat (informational)
// AW       8    RAM beat-address width
// LW       8    job length width (max 2^LW-1 beats)
// RD_LAT   1    operand RAM read latency, rd_en -> data valid at subtractor inputs
// SUB_LAT  2    subtractor register stages (input regs + output reg), must match datapath
// PORTS
// clk        in   1   clock, rising edge
// rst        in   1   asynchronous, active-high reset
// start      in   1   job request; sampled only in IDLE
// cfg_l_base in   AW  first L beat address
// cfg_e_base in   AW  first E beat address
// cfg_d_base in   AW  first result beat address
// cfg_len    in   LW  beats in job; 0 = empty job
// pause      in   1   1 = issue no new reads this cycle; in-flight beats still complete
// abort      in   1   stop issuing; drain in-flight beats, then finish
// busy       out  1   job in ISSUE or DRAIN
// done       out  1   one-cycle pulse at job end
// aborted    out  1   valid with done: job ended by abort
// rd_en      out  1   read strobe to both operand RAMs
// rd_addr_l  out  AW  L RAM address
// rd_addr_e  out  AW  E RAM address
// wr_en      out  1   result RAM write strobe (subtractor output valid this cycle)
// wr_addr    out  AW  result RAM address
// BEHAVIOUR
// - Reset: state=IDLE; busy, done, aborted, rd_en, wr_en = 0; addresses = 0; tag pipe cleared.
// - FSM IDLE->ISSUE on start with cfg_len!=0. IDLE->DONE on start with cfg_len==0.
//   ISSUE->DRAIN after the last beat issues, or on abort. DRAIN->DONE when the tag pipe is empty.
//   DONE->IDLE unconditionally.
// - start: cfg_* latched on acceptance. Ignored outside IDLE. busy=1 from the next cycle.
// - ISSUE: each cycle with pause=0 and abort=0, rd_en=1,
//   rd_addr_l=l_base+idx, rd_addr_e=e_base+idx, idx++.
//   pause=1 gives rd_en=0 with no idx advance. Address sums wrap mod 2^AW.
// - abort in ISSUE: rd_en=0 that cycle, then go to DRAIN. abort in IDLE/DRAIN/DONE is ignored.
//   aborted=1 with done only if abort ended ISSUE before idx==len.
// - Tag pipe: RD_LAT+SUB_LAT shift register of valid bits, shifted every cycle, input=rd_en.
//   wr_en = tail bit. wr_addr = d_base+wcnt, where wcnt increments on each wr_en (wraps).
//   Pause bubbles appear as wr_en gaps at the same spacing.
// - Latency: first wr_en exactly RD_LAT+SUB_LAT cycles after first rd_en. Back-to-back issue
//   gives back-to-back writes.
// - done: 1 for one cycle in DONE; busy=0 in DONE. A new start is accepted from the next IDLE cycle.
// - pause and abort together: abort wins.
// - Reset mid-job: tag pipe cleared, so no further wr_en. Stale subtractor contents are never
//   written. The datapath's own rst is tied to rst externally.
// STRUCTURE
// - Shared package: FSM state encoding (IDLE, ISSUE, DRAIN, DONE) and default W/WC/AW/LW.
// - One sub-module: sub_tag_pipe (parameterised depth valid shift register with empty flag).
//   FSM and address counters stay in this module.
// TESTING
// - len=4, bases L=0x10 E=0x20 D=0x30, RD_LAT=1 SUB_LAT=2 -> rd_en cycles 1-4 (rd_addr_l 0x10-0x13);
//   wr_en cycles 4-7 (wr_addr 0x30-0x33); done at cycle 8. Cycle 0 = start.
// - len=0 -> no rd_en/wr_en; done pulse 1 cycle after start; aborted=0.
// - len=6 with pause high on issue beats 2-3 -> 6 reads with a 2-cycle gap;
//   wr_en shows the same gap; addresses stay contiguous 0..5.
// - l_base=0xFE, len=4 -> rd_addr_l 0xFE,0xFF,0x00,0x01; same wrap on wr_addr.
// - len=10, abort after 3 reads -> exactly 3 writes, then done with aborted=1;
//   start while busy is ignored.
// - Async rst asserted mid-ISSUE -> outputs 0 immediately; no wr_en after release;
//   next job runs cleanly.

Source files
------------

// File: rtl/sub_vec_scheduler_pkg.sv
// Shared definitions for the vector subtractor scheduler: FSM encoding and default widths.
package sub_vec_scheduler_pkg;

   localparam int DEF_W       = 6;
   localparam int DEF_WC      = 32;
   localparam int DEF_AW      = 8;
   localparam int DEF_LW      = 8;
   localparam int DEF_RD_LAT  = 1;
   localparam int DEF_SUB_LAT = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/sub_vec_scheduler_tag_pipe.sv
// Valid-bit shift register that mirrors the fixed-latency operand-read + subtractor pipeline.
module sub_tag_pipe #(
   parameter int DEPTH = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic valid_i,
   output logic valid_o,
   output logic empty_o
);

   logic [DEPTH-1:0] pipe_q;

   // Shift one stage per cycle; the tail bit marks a difference beat leaving the datapath.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_q <= '0;
      end else begin
         pipe_q <= {pipe_q[DEPTH-2:0], valid_i};
      end
   end

   assign valid_o = pipe_q[DEPTH-1];

   // Empty means nothing remains after the current tail beat, so the caller can finish
   // on the same edge that retires the last write.
   assign empty_o = (pipe_q[DEPTH-2:0] == '0) && !valid_i;

endmodule

// File: rtl/sub_vec_scheduler.sv
// Job sequencer for the 32-lane subtractor: issues paired L/E reads, tracks in-flight beats,
// and writes each difference beat to the result RAM at the matching address.
module sub_vec_scheduler
   import sub_vec_scheduler_pkg::*;
#(
   parameter int AW      = DEF_AW,
   parameter int LW      = DEF_LW,
   parameter int RD_LAT  = DEF_RD_LAT,
   parameter int SUB_LAT = DEF_SUB_LAT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] cfg_l_base,
   input  logic [AW-1:0] cfg_e_base,
   input  logic [AW-1:0] cfg_d_base,
   input  logic [LW-1:0] cfg_len,
   input  logic          pause,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic          aborted,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr_l,
   output logic [AW-1:0] rd_addr_e,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr
);

   localparam int PIPE_DEPTH = RD_LAT + SUB_LAT;

   state_e        state_q;
   logic          busy_q;
   logic          done_q;
   logic          aborted_q;
   logic          abort_seen_q;
   logic [LW-1:0] len_q;
   logic [LW-1:0] idx_q;
   logic [AW-1:0] addr_l_q;
   logic [AW-1:0] addr_e_q;
   logic [AW-1:0] addr_d_q;
   logic          issue;
   logic          last_beat;
   logic          pipe_empty;

   // Read issue decision; abort takes priority over pause and suppresses the read this cycle.
   always_comb begin
      issue     = 1'b0;
      last_beat = 1'b0;
      if (state_q == ST_ISSUE) begin
         issue     = !pause && !abort;
         last_beat = issue && (idx_q == (len_q - LW'(1)));
      end else begin
         issue     = 1'b0;
         last_beat = 1'b0;
      end
   end

   // Job FSM with its address counters and registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
         abort_seen_q <= 1'b0;
         len_q        <= '0;
         idx_q        <= '0;
         addr_l_q     <= '0;
         addr_e_q     <= '0;
         addr_d_q     <= '0;
      end else begin
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         if (wr_en) begin
            addr_d_q <= addr_d_q + AW'(1);
         end
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  len_q        <= cfg_len;
                  idx_q        <= '0;
                  addr_l_q     <= cfg_l_base;
                  addr_e_q     <= cfg_e_base;
                  addr_d_q     <= cfg_d_base;
                  abort_seen_q <= 1'b0;
                  if (cfg_len == '0) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_ISSUE;
                     busy_q  <= 1'b1;
                  end
               end
            end
            ST_ISSUE: begin
               if (abort) begin
                  state_q      <= ST_DRAIN;
                  abort_seen_q <= 1'b1;
               end else if (issue) begin
                  idx_q    <= idx_q + LW'(1);
                  addr_l_q <= addr_l_q + AW'(1);
                  addr_e_q <= addr_e_q + AW'(1);
                  if (last_beat) begin
                     state_q <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (pipe_empty) begin
                  state_q   <= ST_DONE;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  aborted_q <= abort_seen_q;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   sub_tag_pipe #(
      .DEPTH (PIPE_DEPTH)
   ) u_tag_pipe (
      .clk     (clk),
      .rst     (rst),
      .valid_i (issue),
      .valid_o (wr_en),
      .empty_o (pipe_empty)
   );

   assign rd_en     = issue;
   assign rd_addr_l = addr_l_q;
   assign rd_addr_e = addr_e_q;
   assign wr_addr   = addr_d_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign aborted   = aborted_q;

endmodule

// File: tb/tb_sub_vec_scheduler.sv
// Randomised and directed jobs checked cycle by cycle against an event-list model of the scheduler.
module tb_sub_vec_scheduler;

   localparam int LAT = 3;
   localparam int NC  = 320;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       pause;
   logic       abort;
   logic [7:0] cfg_l_base;
   logic [7:0] cfg_e_base;
   logic [7:0] cfg_d_base;
   logic [7:0] cfg_len;
   logic       busy;
   logic       done;
   logic       aborted;
   logic       rd_en;
   logic [7:0] rd_addr_l;
   logic [7:0] rd_addr_e;
   logic       wr_en;
   logic [7:0] wr_addr;

   int checks_cnt = 0;
   int errors_cnt = 0;

   bit pz [NC];
   bit ab [NC];
   bit sb [NC];
   bit exp_rd [NC];
   bit exp_wr [NC];
   int rd_idx [NC];
   int wr_idx [NC];

   sub_vec_scheduler dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .cfg_l_base (cfg_l_base),
      .cfg_e_base (cfg_e_base),
      .cfg_d_base (cfg_d_base),
      .cfg_len    (cfg_len),
      .pause      (pause),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .aborted    (aborted),
      .rd_en      (rd_en),
      .rd_addr_l  (rd_addr_l),
      .rd_addr_e  (rd_addr_e),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks_cnt++;
      if (got !== expv) begin
         errors_cnt++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, expv, $time);
      end
   endtask

   task automatic clear_stim();
      for (int c = 0; c < NC; c++) begin
         pz[c] = 1'b0;
         ab[c] = 1'b0;
         sb[c] = 1'b0;
      end
   endtask

   // Entry and exit: just after a rising edge with the DUT idle.
   task automatic run_job(input logic [7:0] l, input logic [7:0] e, input logic [7:0] d,
                          input logic [7:0] len);
      int done_c;
      int issue_end;
      int last_rd;
      int n;
      bit exp_ab;
      for (int c = 0; c < NC; c++) begin
         exp_rd[c] = 1'b0;
         exp_wr[c] = 1'b0;
         rd_idx[c] = 0;
         wr_idx[c] = 0;
      end
      exp_ab = 1'b0;
      n = 0;
      issue_end = 1;
      last_rd = 0;
      if (len == 8'd0) begin
         done_c = 1;
      end else begin
         for (int c = 1; c < NC - 8; c++) begin
            if (ab[c]) begin
               exp_ab = 1'b1;
               issue_end = c;
               break;
            end
            if (!pz[c]) begin
               exp_rd[c] = 1'b1;
               rd_idx[c] = n;
               exp_wr[c + LAT] = 1'b1;
               wr_idx[c + LAT] = n;
               n++;
               last_rd = c;
               if (n == int'(len)) begin
                  issue_end = c;
                  break;
               end
            end
         end
         done_c = issue_end + 2;
         if (n > 0 && last_rd + LAT + 1 > done_c) done_c = last_rd + LAT + 1;
      end

      for (int c = 0; c <= done_c; c++) begin
         if (c == 0) begin
            start = 1'b1;
            cfg_l_base = l;
            cfg_e_base = e;
            cfg_d_base = d;
            cfg_len = len;
         end else begin
            start = sb[c];
            cfg_l_base = 8'($urandom);
            cfg_e_base = 8'($urandom);
            cfg_d_base = 8'($urandom);
            cfg_len = 8'($urandom);
         end
         pause = pz[c];
         abort = ab[c];
         @(negedge clk);
         chk("rd_en", 32'(rd_en), 32'(exp_rd[c]));
         if (exp_rd[c]) begin
            chk("rd_addr_l", 32'(rd_addr_l), 32'((int'(l) + rd_idx[c]) % 256));
            chk("rd_addr_e", 32'(rd_addr_e), 32'((int'(e) + rd_idx[c]) % 256));
         end
         chk("wr_en", 32'(wr_en), 32'(exp_wr[c]));
         if (exp_wr[c]) begin
            chk("wr_addr", 32'(wr_addr), 32'((int'(d) + wr_idx[c]) % 256));
         end
         chk("busy", 32'(busy), 32'(len != 8'd0 && c >= 1 && c < done_c));
         chk("done", 32'(done), 32'(c == done_c));
         chk("aborted", 32'(aborted), 32'(c == done_c && exp_ab));
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      pause = 1'b0;
      abort = 1'b0;
   endtask

   initial begin
      int len_r;
      int pct;
      rst = 1'b1;
      start = 1'b0;
      pause = 1'b0;
      abort = 1'b0;
      cfg_l_base = 8'd0;
      cfg_e_base = 8'd0;
      cfg_d_base = 8'd0;
      cfg_len = 8'd0;
      @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_aborted", 32'(aborted), 32'd0);
      chk("rst_rd_en", 32'(rd_en), 32'd0);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_rd_addr_l", 32'(rd_addr_l), 32'd0);
      chk("rst_rd_addr_e", 32'(rd_addr_e), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      clear_stim();
      run_job(8'h10, 8'h20, 8'h30, 8'd4);
      clear_stim();
      run_job(8'h11, 8'h22, 8'h33, 8'd0);
      clear_stim();
      pz[2] = 1'b1;
      pz[3] = 1'b1;
      run_job(8'h00, 8'h40, 8'h80, 8'd6);
      clear_stim();
      run_job(8'hFE, 8'h7F, 8'hFE, 8'd4);
      clear_stim();
      ab[4] = 1'b1;
      for (int c = 1; c < 20; c++) sb[c] = 1'b1;
      run_job(8'h05, 8'h06, 8'h07, 8'd10);

      // Reset in the middle of ISSUE, then a clean job.
      start = 1'b1;
      cfg_l_base = 8'h50;
      cfg_e_base = 8'h60;
      cfg_d_base = 8'h70;
      cfg_len = 8'd8;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("pre_rst_rd_en", 32'(rd_en), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_rd_en", 32'(rd_en), 32'd0);
      chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_rd_addr_l", 32'(rd_addr_l), 32'd0);
      chk("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("post_rst_wr_en", 32'(wr_en), 32'd0);
         chk("post_rst_rd_en", 32'(rd_en), 32'd0);
         chk("post_rst_busy", 32'(busy), 32'd0);
         @(posedge clk);
         #1;
      end
      clear_stim();
      run_job(8'h50, 8'h60, 8'h70, 8'd5);

      for (int j = 0; j < 40; j++) begin
         clear_stim();
         len_r = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 24));
         pct = int'($urandom_range(0, 40));
         for (int c = 1; c < 200; c++) pz[c] = ($urandom_range(0, 99) < pct);
         for (int c = 0; c < 200; c++) ab[c] = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 3) == 0) ab[$urandom_range(1, 2 * len_r + 2)] = 1'b1;
         for (int c = 1; c < NC; c++) sb[c] = ($urandom_range(0, 99) < 15);
         run_job(8'($urandom), 8'($urandom), 8'($urandom), 8'(len_r));
      end

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
